// File: rtl/machine_d_fsm.sv
// Eight-state up/down ring counter FSM: x=1 steps forward, x=0 steps backward, F flags FLAG_STATE.
// Define MACHINE_D_GRAY_EN to present S as the Gray code of the internal binary state.
module machine_d_fsm #(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter logic [2:0] FLAG_STATE  = 3'd7
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       x,
    output logic       F,
    output logic [2:0] S
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= state_next;
        end
    end

    // Ring arithmetic relies on 3-bit wraparound: 7+1 -> 0 and 0-1 -> 7.
    always_comb begin
        state_next = state;
        if (x) begin
            state_next = state_t'(state + 3'd1);
        end else begin
            state_next = state_t'(state - 3'd1);
        end
    end

    always_comb begin
        logic [2:0] b;
        b = state;
        F = (b == FLAG_STATE);
`ifdef MACHINE_D_GRAY_EN
        S = b ^ (b >> 1);
`else
        S = b;
`endif
    end

endmodule

// File: tb/tb_machine_d_fsm.sv
// Randomized self-checking bench for machine_d_fsm against a modular-arithmetic reference model.
`timescale 1ns/1ps
module tb_machine_d_fsm;

    logic       CLK;
    logic       RESET;
    logic       x;
    logic       F;
    logic [2:0] S;

    int n_checks;
    int n_pass;
    int mdl;
    logic [2:0] prev_s;

    machine_d_fsm #(
        .RESET_STATE(3'd0),
        .FLAG_STATE (3'd7)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .x    (x),
        .F    (F),
        .S    (S)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_s(input int b);
`ifdef MACHINE_D_GRAY_EN
        return 3'(b ^ (b >> 1));
`else
        return 3'(b);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, ".S"}, {29'd0, S}, {29'd0, exp_s(mdl)});
        check({tag, ".F"}, {31'd0, F}, {31'd0, (mdl == 7)});
    endtask

    // Apply one clocked step; x is held stable across the sampling edge.
    task automatic step(input logic xv, input string tag);
        prev_s = S;
        x = xv;
        @(posedge CLK);
        #1;
        mdl = (mdl + (xv ? 1 : 7)) % 8;
        check_out(tag);
`ifdef MACHINE_D_GRAY_EN
        check({tag, ".gray1bit"}, $countones(S ^ prev_s), 1);
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2;
        RESET = 1'b0;
        #1;
        mdl = 0;
        check_out(tag);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mdl      = 0;
        RESET    = 1'b0;
        x        = 1'b0;

        // Held in reset with clock running and random x.
        for (int i = 0; i < 4; i++) begin
            x = 1'($urandom_range(0, 1));
            @(posedge CLK);
            #1;
            check_out("in_reset");
        end
        RESET = 1'b1;
        #2;
        check_out("release_no_change");
        step(1'b0, "release_back");

        async_reset("rst_fwd");
        for (int i = 0; i < 8; i++) step(1'b1, "fwd");

        async_reset("rst_back");
        for (int i = 0; i < 3; i++) step(1'b0, "back");

        async_reset("rst_dir");
        for (int i = 0; i < 3; i++) step(1'b1, "to3");
        step(1'b1, "dir");
        step(1'b1, "dir");
        step(1'b0, "dir");
        step(1'b0, "dir");
        step(1'b0, "dir");

        async_reset("rst_async");
        for (int i = 0; i < 5; i++) step(1'b1, "to5");
        async_reset("async_mid");
        step(1'b1, "resume");
        step(1'b1, "resume");

        // Random walk with mid-cycle x wiggles and occasional async reset.
        for (int i = 0; i < 200; i++) begin
            logic xv;
            x = 1'($urandom_range(0, 1));
            #2;
            check_out("rnd_midcycle_hold");
            x = ~x;
            #1;
            check_out("rnd_x_indep");
            xv = 1'($urandom_range(0, 1));
            step(xv, "rnd");
            if ($urandom_range(0, 19) == 0) async_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
